// File: rtl/uart_pkg.sv
// Shared state encoding and sample-point helpers for the oversampling UART receiver.
// Build option: UART_RX_PARITY_EN adds the PARITY state.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } state_e;

   localparam int unsigned OVS_DEFAULT = 16;

   function automatic int unsigned tick_mid(input int unsigned ovs);
      return ovs / 2;
   endfunction

   function automatic int unsigned tick_early(input int unsigned ovs);
      return ovs / 2 - 1;
   endfunction

   function automatic int unsigned tick_late(input int unsigned ovs);
      return ovs / 2 + 1;
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_ovs_if.sv
// Receive-word handshake between the UART receiver (master) and its consumer (slave).
interface uart_rx_ovs_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every CLK_DIV_COUNT clocks, restartable
// so the tick phase locks to the detected start edge.
module uart_baud_tick #(
   parameter int unsigned CLK_DIV_COUNT = 25,
   parameter int unsigned CLK_DIV_WIDTH = 8
) (
   input  logic clk_in,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam logic [CLK_DIV_WIDTH-1:0] LOAD = CLK_DIV_WIDTH'(CLK_DIV_COUNT - 1);
   localparam logic [CLK_DIV_WIDTH-1:0] TC   = CLK_DIV_WIDTH'(1);

   logic [CLK_DIV_WIDTH-1:0] cnt_q, cnt_d;

   // Down-counter sits at 0 for one cycle after restart/terminal count, then reloads,
   // so terminal count (1) is reached exactly CLK_DIV_COUNT cycles after restart.
   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (restart) begin
         cnt_d = '0;
      end else if (cnt_q == '0) begin
         cnt_d = LOAD;
      end else begin
         cnt_d = cnt_q - TC;
         tick  = (cnt_q == TC);
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver FSM with majority-vote bit sampling and valid/ready output.
// Build option: UART_RX_PARITY_EN enables the parity bit check and rx_parity_err.
module uart_rx_ovs
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV_COUNT = 25,
   parameter int unsigned CLK_DIV_WIDTH = 8,
   parameter int unsigned OVERSAMPLE    = OVS_DEFAULT,
   parameter int unsigned DATA_BITS     = 8,
   parameter int unsigned STOP_BITS     = 1,
   parameter int unsigned PARITY_ODD    = 0
) (
   input  logic          clk_in,
   input  logic          reset,
   input  logic          rx_line_beforesync,
   uart_rx_ovs_if.master rx_if,
`ifdef UART_RX_PARITY_EN
   output logic          rx_parity_err,
`endif
   output logic          rx_running,
   output logic          rx_invalid,
   output logic          rx_overrun
);

   // state     | meaning
   // ST_IDLE   | line idle, watching for a 1->0 edge
   // ST_START  | confirming start bit at its middle tick
   // ST_DATA   | sampling DATA_BITS data bits, LSB first
   // ST_PARITY | sampling and checking the parity bit
   // ST_STOP   | sampling stop bit(s); good last stop loads the word
   // ST_BREAK  | framing error, waiting for the line to return high

   if (OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0 ||
       DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
       PARITY_ODD > 1 || (2 ** CLK_DIV_WIDTH) <= CLK_DIV_COUNT) begin : g_bad_param
      $error("uart_rx_ovs: illegal parameter set");
   end

   localparam int unsigned TW = $clog2(OVERSAMPLE + 1);
   localparam logic [TW-1:0] T_EARLY = TW'(tick_early(OVERSAMPLE));
   localparam logic [TW-1:0] T_MID   = TW'(tick_mid(OVERSAMPLE));
   localparam logic [TW-1:0] T_LATE  = TW'(tick_late(OVERSAMPLE));
   localparam logic [TW-1:0] T_END   = TW'(OVERSAMPLE);
   localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
`ifdef UART_RX_PARITY_EN
   localparam logic          PAR_ODD   = 1'(PARITY_ODD);
`endif

   state_e               state_q, state_d;
   logic                 sync1_q, sync1_d;
   logic                 sync2_q, sync2_d;
   logic                 prev_q, prev_d;
   logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic [1:0]           samp_q, samp_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 invalid_q, invalid_d;
   logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
   logic                 par_bad_q, par_bad_d;
   logic                 parity_err_q, parity_err_d;
`endif

   logic          tick;
   logic          restart;
   logic          fall;
   logic          load;
   logic          decide;
   logic          bit_end;
   logic          bit_val;
   logic [TW-1:0] tick_n;

   uart_baud_tick #(
      .CLK_DIV_COUNT (CLK_DIV_COUNT),
      .CLK_DIV_WIDTH (CLK_DIV_WIDTH)
   ) u_baud_tick (
      .clk_in  (clk_in),
      .reset   (reset),
      .restart (restart),
      .tick    (tick)
   );

   always_comb begin
      sync1_d    = rx_line_beforesync;
      sync2_d    = sync1_q;
      prev_d     = sync2_q;
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      samp_d     = samp_q;
      shift_d    = shift_q;
      invalid_d  = 1'b0;
      restart    = 1'b0;
      load       = 1'b0;
      decide     = 1'b0;
      bit_end    = 1'b0;
      fall       = prev_q & ~sync2_q;
      tick_n     = tick_cnt_q + 1'b1;
      bit_val    = maj3(samp_q[1], samp_q[0], sync2_q);
`ifdef UART_RX_PARITY_EN
      par_bad_d    = par_bad_q;
      parity_err_d = 1'b0;
`endif

      // Common bit timing for every majority-voted bit.
      if (tick && (state_q == ST_DATA || state_q == ST_STOP
`ifdef UART_RX_PARITY_EN
                   || state_q == ST_PARITY
`endif
                  )) begin
         tick_cnt_d = tick_n;
         if (tick_n == T_EARLY) samp_d[1] = sync2_q;
         if (tick_n == T_MID)   samp_d[0] = sync2_q;
         decide  = (tick_n == T_LATE);
         bit_end = (tick_n == T_END);
         if (bit_end) tick_cnt_d = '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (fall) begin
               state_d    = ST_START;
               restart    = 1'b1;
               tick_cnt_d = '0;
            end
         end
         ST_START: begin
            if (tick) begin
               tick_cnt_d = tick_n;
               if (tick_n == T_MID && sync2_q) begin
                  state_d = ST_IDLE;
               end else if (tick_n == T_END) begin
                  tick_cnt_d = '0;
                  bit_cnt_d  = '0;
                  state_d    = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (decide) shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
            if (bit_end) begin
               if (bit_cnt_q == BIT_LAST) begin
                  stop_cnt_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                  par_bad_d = 1'b0;
                  state_d   = ST_PARITY;
`else
                  state_d   = ST_STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (decide && ((^shift_q) ^ bit_val) != PAR_ODD) begin
               par_bad_d    = 1'b1;
               parity_err_d = 1'b1;
            end
            if (bit_end) state_d = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (decide) begin
               if (!bit_val) begin
                  invalid_d = 1'b1;
                  state_d   = ST_BREAK;
               end else if (stop_cnt_q == STOP_LAST) begin
                  state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                  load    = ~par_bad_q;
`else
                  load    = 1'b1;
`endif
               end
            end
            if (bit_end) stop_cnt_d = 1'b1;
         end
         ST_BREAK: begin
            if (sync2_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output word register: a load coinciding with an accept replaces the word,
   // a load into an unaccepted word is dropped and flagged.
   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;
      if (valid_q && rx_if.rx_ready) valid_d = 1'b0;
      if (load) begin
         if (valid_q && !rx_if.rx_ready) begin
            overrun_d = 1'b1;
         end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         prev_q     <= 1'b1;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         samp_q     <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         invalid_q  <= 1'b0;
         overrun_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         prev_q     <= prev_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         samp_q     <= samp_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         invalid_q  <= invalid_d;
         overrun_q  <= overrun_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign rx_if.rx_data  = data_q;
   assign rx_if.rx_valid = valid_q;
   assign rx_running     = (state_q != ST_IDLE);
   assign rx_invalid     = invalid_q;
   assign rx_overrun     = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign rx_parity_err  = parity_err_q;
`endif

endmodule

// File: doc/uart_rx_ovs.md
UART_RX_OVS -- requirements
Module: uart_rx_ovs

Interface
REQ-001 Parameter CLK_DIV_COUNT, default 25: clk_in cycles per oversample tick.
REQ-002 Parameter CLK_DIV_WIDTH, default 8: width of the tick divider counter; must satisfy 2**CLK_DIV_WIDTH > CLK_DIV_COUNT.
REQ-003 Parameter OVERSAMPLE, default 16: ticks per bit, even, range 8..32.
REQ-004 Parameter DATA_BITS, default 8: data bits per frame, range 5..9.
REQ-005 Parameter STOP_BITS, default 1: stop bits checked, 1 or 2.
REQ-006 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity; used only with UART_RX_PARITY_EN.
REQ-007 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 rx_line_beforesync  input  1  asynchronous serial line, idle high.
REQ-010 rx_ready  input  1  consumer accepts rx_data when it is high while rx_valid is high.
REQ-011 rx_data  output  DATA_BITS  received word, LSB received first.
REQ-012 rx_valid  output  1  rx_data holds an unconsumed word.
REQ-013 rx_running  output  1  high from start-edge detection until the frame ends or is aborted.
REQ-014 rx_invalid  output  1  one-cycle pulse on a framing error.
REQ-015 rx_overrun  output  1  one-cycle pulse when a completed word is dropped.
REQ-016 rx_parity_err  output  1  one-cycle pulse on a parity mismatch; present only with UART_RX_PARITY_EN.

Function
REQ-017 The line shall pass through a 2-flop synchronizer; both flops reset to 1, and all logic uses the synchronized value.
REQ-018 Ticks shall be generated every CLK_DIV_COUNT clk_in cycles; the divider restarts at 0 on the cycle a start edge is detected.
REQ-019 States: IDLE, START, DATA, PARITY (parity build only), STOP, BREAK.
REQ-020 IDLE->START on a synchronized 1->0 transition; rx_running asserts on that cycle.
REQ-021 START: at tick OVERSAMPLE/2, a low sample -> DATA; a high sample -> IDLE silently (glitch; no flags raised).
REQ-022 Each data, parity and stop bit is the 2-of-3 majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit.
REQ-023 DATA shifts DATA_BITS bits LSB-first, then goes to PARITY if parity is compiled in, otherwise to STOP.
REQ-024 STOP: every stop bit must sample high; any low stop bit pulses rx_invalid, discards the word and goes to BREAK.
REQ-025 BREAK waits for the synchronized line to be high, then goes to IDLE; rx_running deasserts on leaving BREAK.
REQ-026 On a good last stop bit, the word loads into the output register one clk_in cycle after the majority decision, the FSM returns to IDLE and rx_running deasserts on that same cycle.
REQ-027 Handshake: rx_valid stays high and rx_data stays stable until the cycle on which rx_valid and rx_ready are both high; rx_valid clears on the next cycle.
REQ-028 Load while rx_valid=1 and rx_ready=0: the new word is dropped, rx_overrun pulses and the old word is kept.
REQ-029 Load on the same cycle as an accept: the new word is loaded, rx_valid stays 1 and rx_overrun is not raised.
REQ-030 A start edge is accepted on the cycle immediately after return to IDLE (back-to-back frames).

Reset
REQ-031 Reset values: FSM=IDLE, rx_data=0, rx_valid=0, rx_running=0, rx_invalid=0, rx_overrun=0, rx_parity_err=0, divider=0, synchronizer=1.
REQ-032 Reset mid-frame shall abort the frame with no output pulses; normal operation starts on the first cycle after reset deasserts.

Configuration
REQ-033 Macro UART_RX_PARITY_EN.
- Defined: a PARITY bit follows the data bits and is checked against PARITY_ODD. On mismatch, rx_parity_err pulses, the word is discarded and the FSM continues to STOP.
- Undefined: no PARITY state, no parity bit in the frame, and no rx_parity_err port.

Structure
REQ-034 Package uart_pkg shall hold the FSM state enum and the sample-tick constants (MID, MID-1, MID+1) derived from OVERSAMPLE.
REQ-035 Sub-module uart_baud_tick (restartable CLK_DIV_COUNT tick generator); the rest shall be a single FSM module.

Verification (CLK_DIV_COUNT=25, OVERSAMPLE=16, 400 clk_in per bit)
REQ-036 "A","B","C" (0x41, 0x42, 0x43) back-to-back, 8N1, rx_ready=1 -> three rx_valid pulses carrying 0x41, 0x42, 0x43; no flags.
REQ-037 Low glitch of 100 clk_in cycles on an idle line -> rx_running pulses, then returns to IDLE; rx_valid=0 and rx_invalid=0.
REQ-038 0x55 sent with a low stop bit -> rx_invalid pulses once; rx_valid stays 0; next frame 0x41 is received correctly.
REQ-039 rx_ready=0 while 0x41 and then 0x42 are sent -> rx_overrun pulses once; rx_data=0x41 is held; raising rx_ready accepts 0x41.
REQ-040 Reset asserted at mid data bit 3 of 0xA5 -> all outputs return to 0; the following 0x3C is received correctly.
REQ-041 Parity build, even parity, 0x41 sent with parity bit 1 -> rx_parity_err pulses and rx_valid stays 0; with parity bit 0 -> 0x41 is delivered.
